// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks a register-file address range and streams each register out with a valid/ready handshake
// Optional feature: define REGDUMP_SKIP_ZERO_EN to skip register 0 during a dump.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] end_ptr;

  // The read port always sees the pointer, so it is never left floating.
  assign rf_addr = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      end_ptr    <= '0;
      dout_addr  <= '0;
      dout_data  <= '0;
      word_cnt   <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr      <= first_addr;
            end_ptr  <= last_addr;
            word_cnt <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
`ifdef REGDUMP_SKIP_ZERO_EN
          if (ptr == '0) begin
            if (ptr == end_ptr) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end else
`endif
          begin
            dout_addr  <= ptr;
            dout_data  <= rf_data;
            dout_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            word_cnt   <= word_cnt + 1'b1;
            if (ptr == end_ptr) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= READ;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
